// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO.
// Pointer wrap and count sizing for arbitrary depths.
package fifo_pkg;

  function automatic int unsigned cnt_width(
    input int unsigned depth
  );
    return $clog2(depth + 1);
  endfunction

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic int unsigned next_ptr(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo.
// Synchronous write; read port registered or fall-through.
module sync_fifo_ram #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = 0,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic unused_rd;
      assign unused_rd = ^{rst, re};
      assign rdata = mem[raddr];
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, flags, sticky errors.
// Any depth >= 2, optional first-word-fall-through read.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE         = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int CSIZE        = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CSIZE-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CSIZE-1:0] FULL_C = CSIZE'(DEPTH);
  localparam logic [CSIZE-1:0] AF_C   = CSIZE'(AFULL_THRESH);
  localparam logic [CSIZE-1:0] AE_C   = CSIZE'(AEMPTY_THRESH);

  logic [AW-1:0]    wptr, rptr;
  logic [CSIZE-1:0] cnt_next;
  logic             wr_ok, rd_ok;

  assign wr_ok = winc && !wfull && !flush;
  assign rd_ok = rinc && !rempty && !flush;

  always_comb begin
    cnt_next = count;
    if (flush)               cnt_next = '0;
    else if (wr_ok && !rd_ok) cnt_next = count + 1'b1;
    else if (rd_ok && !wr_ok) cnt_next = count - 1'b1;
  end

  // Flags decode the next count so they move with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_ok) wptr <= AW'(next_ptr(32'(wptr), DEPTH));
        if (rd_ok) rptr <= AW'(next_ptr(32'(rptr), DEPTH));
        if (winc && wfull)  overflow  <= 1'b1;
        if (rinc && rempty) underflow <= 1'b1;
      end
      count        <= cnt_next;
      wfull        <= (cnt_next == FULL_C);
      rempty       <= (cnt_next == '0);
      almost_full  <= (cnt_next >= AF_C);
      almost_empty <= (cnt_next <= AE_C);
    end
  end

  sync_fifo_ram #(
    .DSIZE (DSIZE),
    .DEPTH (DEPTH),
    .FWFT  (FWFT),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok && !rst),
    .waddr (wptr),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo.
// u0: DEPTH=5 registered read; u1: DEPTH=5 FWFT.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       flush0 = 0, winc0 = 0, rinc0 = 0;
  logic [7:0] wdata0 = 0, rdata0;
  logic       wfull0, rempty0, af0, ae0, ovf0, udf0;
  logic [2:0] count0;

  logic       flush1 = 0, winc1 = 0, rinc1 = 0;
  logic [7:0] wdata1 = 0, rdata1;
  logic       wfull1, rempty1, af1, ae1, ovf1, udf1;
  logic [2:0] count1;

  sync_fifo #(
    .DSIZE(8), .DEPTH(5), .FWFT(0),
    .AFULL_THRESH(4), .AEMPTY_THRESH(1)
  ) u0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .winc(winc0), .wdata(wdata0), .rinc(rinc0),
    .rdata(rdata0), .wfull(wfull0), .rempty(rempty0),
    .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo #(
    .DSIZE(8), .DEPTH(5), .FWFT(1)
  ) u1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .winc(winc1), .wdata(wdata1), .rinc(rinc1),
    .rdata(rdata1), .wfull(wfull1), .rempty(rempty1),
    .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(udf1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int m0 = 0;
  int m1 = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // u0 read data appears one cycle after an accepted read.
  always @(posedge clk) begin
    if (!rst && !flush0 && rinc0 && !rempty0) begin
      #1;
      if (exp0.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rdata0: read %0h with nothing expected", rdata0);
      end else begin
        chk("rdata0", rdata0, exp0.pop_front());
      end
    end
  end

  // u1 head is visible whenever it is not empty.
  always @(negedge clk) begin
    if (!rst && !rempty1) begin
      if (exp1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rdata1: head %0h with nothing expected", rdata1);
      end else begin
        chk("rdata1", rdata1, exp1[0]);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && !flush1 && rinc1 && !rempty1 && exp1.size() > 0)
      void'(exp1.pop_front());
  end

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    winc0 = 0; rinc0 = 0; flush0 = 0;
    winc1 = 0; rinc1 = 0; flush1 = 0;
    m0 = 0; m1 = 0;
    exp0.delete();
    exp1.delete();
  endtask

  task automatic cyc0(input logic w, input logic [7:0] d,
                      input logic r, input logic f);
    bit wa, ra;
    winc0 = w; wdata0 = d; rinc0 = r; flush0 = f;
    if (f) begin
      m0 = 0;
      exp0.delete();
    end else begin
      wa = w && (m0 < 5);
      ra = r && (m0 > 0);
      if (wa) exp0.push_back(d);
      m0 = m0 + int'(wa) - int'(ra);
    end
    @(posedge clk);
    #1;
    winc0 = 0; rinc0 = 0; flush0 = 0;
    chk("count0", count0, m0);
    chk("wfull0", wfull0, m0 == 5);
    chk("rempty0", rempty0, m0 == 0);
    chk("aempty0", ae0, m0 <= 1);
    chk("afull0", af0, m0 >= 4);
  endtask

  task automatic cyc1(input logic w, input logic [7:0] d,
                      input logic r);
    bit wa, ra;
    winc1 = w; wdata1 = d; rinc1 = r;
    wa = w && (m1 < 5);
    ra = r && (m1 > 0);
    if (wa) exp1.push_back(d);
    m1 = m1 + int'(wa) - int'(ra);
    @(posedge clk);
    #1;
    winc1 = 0; rinc1 = 0;
    chk("count1", count1, m1);
    chk("rempty1", rempty1, m1 == 0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    do_rst();
    chk("rst_rdata0", rdata0, 8'h00);
    chk("rst_count0", count0, 0);
    chk("rst_wfull0", wfull0, 0);
    chk("rst_rempty0", rempty0, 1);
    chk("rst_ae0", ae0, 1);
    chk("rst_af0", af0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_udf0", udf0, 0);
    chk("rst_rempty1", rempty1, 1);

    for (int i = 1; i <= 5; i++) cyc0(1, 8'(i * 17), 0, 0);
    chk("fill_full", wfull0, 1);
    chk("fill_count", count0, 5);
    cyc0(1, 8'h66, 0, 0);
    chk("ovf_set", ovf0, 1);
    for (int i = 0; i < 5; i++) cyc0(0, 8'h00, 1, 0);
    chk("drain_empty", rempty0, 1);
    chk("drain_udf", udf0, 0);

    for (int i = 0; i < 7; i++) begin
      cyc0(1, 8'hA0 + 8'(i), 0, 0);
      cyc0(0, 8'h00, 1, 0);
    end

    for (int i = 0; i < 3; i++) cyc0(1, 8'hB0 + 8'(i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc0(1, 8'hC0 + 8'(i), 1, 0);
      chk("steady_count", count0, 3);
    end

    cyc0(1, 8'hD0, 0, 0);
    cyc0(1, 8'hD1, 0, 0);
    cyc0(1, 8'hEE, 1, 0);
    chk("full_rw_count", count0, 4);
    chk("full_rw_af", af0, 1);

    cyc0(1, 8'h99, 1, 1);
    chk("flush_count", count0, 0);
    chk("flush_rdata", rdata0, 8'hC7);
    chk("flush_ovf", ovf0, 1);
    chk("flush_udf", udf0, 0);
    cyc0(1, 8'h77, 0, 0);
    cyc0(0, 8'h00, 1, 0);
    cyc0(0, 8'h00, 1, 0);
    chk("udf0_set", udf0, 1);

    winc0 = 1; wdata0 = 8'h5A;
    do_rst();
    chk("rst2_ovf", ovf0, 0);
    chk("rst2_udf", udf0, 0);
    chk("rst2_count", count0, 0);
    chk("rst2_rdata", rdata0, 8'h00);

    for (int i = 1; i <= 5; i++) cyc0(1, 8'hE0 + 8'(i), 0, 0);
    cyc0(1, 8'hF0, 1, 1);
    chk("flush_full_ovf", ovf0, 0);
    cyc0(0, 8'h00, 1, 1);
    chk("flush_empty_udf", udf0, 0);
    chk("flush_rdata2", rdata0, 8'h00);

    cyc1(1, 8'hA5, 0);
    chk("fwft_head", rdata1, 8'hA5);
    cyc1(0, 8'h00, 1);
    chk("fwft_udf_pre", udf1, 0);
    cyc1(0, 8'h00, 1);
    chk("fwft_udf", udf1, 1);
    chk("fwft_ovf", ovf1, 0);

    @(posedge clk);
    #1;
    chk("sb0_left", exp0.size(), 0);
    chk("sb1_left", exp1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
